// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a producer of binary values and the
// bin2bcd_seq converter. The producer owns ld/bin; the converter owns
// the result, busy and done.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  ld;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;

  modport master (
    output ld,
    output bin,
    input  bcd,
    input  busy,
    input  done
  );

  modport slave (
    input  ld,
    input  bin,
    output bcd,
    output busy,
    output done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift/add-3 (double dabble).
// One binary bit is consumed per clock; a WIDTH-bit value takes WIDTH
// clocks after the load edge, then done pulses for one cycle with the
// packed digits on bcd. bcd only changes on completion, so the display
// downstream never sees a partial result.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] binreg_q, binreg_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [BW-1:0]   corrected_s;
  logic [BW-1:0]   shifted_s;

  // Add 3 to every digit that is 5 or more so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Digit correction and the scratch half of the combined left shift.
  always_comb begin
    corrected_s = add3_digits(scratch_q);
    shifted_s   = {corrected_s[BW-2:0], binreg_q[WIDTH-1]};
  end

  // Next-state logic for the FSM, datapath and registered outputs.
  always_comb begin
    state_d   = state_q;
    binreg_d  = binreg_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          binreg_d  = bus.bin;
          scratch_d = {BW{1'b0}};
          count_d   = CW'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end else begin
          busy_d    = 1'b0;
        end
      end
      SHIFT: begin
        scratch_d = shifted_s;
        binreg_d  = {binreg_q[WIDTH-2:0], 1'b0};
        count_d   = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          // Last bit consumed: publish the result and return to idle.
          bcd_d   = shifted_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        count_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset wins over everything, including a
  // conversion in flight, which is simply abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      binreg_q  <= {WIDTH{1'b0}};
      scratch_q <= {BW{1'b0}};
      count_q   <= {CW{1'b0}};
      bcd_q     <= {BW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      binreg_q  <= binreg_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: a behavioural model (decimal arithmetic and a
// latency countdown) is compared with the DUT on every cycle, and directed
// scenarios add literal expectations for results and latencies.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic clk;
  logic rst;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vec  = 0;
  int miss = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [BW-1:0]    m_bcd  = '0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_left = 0;
  logic [WIDTH-1:0] m_val  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a load in idle starts a WIDTH-cycle countdown,
  // completion publishes the decimal digits of the loaded value.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_bcd  <= to_bcd(int'(m_val));
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.ld) begin
        m_val  <= bus.bin;
        m_left <= WIDTH;
        m_busy <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_bcd",  32'(bus.bcd),  32'(m_bcd));
      chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
      chk("cyc_done", 32'(bus.done), 32'(m_done));
      chk("cyc_excl", 32'(bus.busy & bus.done), 32'd0);
    end
  end

  // Pulse ld for one cycle; returns at the negedge after the ld edge.
  task automatic do_ld(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bus.ld  = 1'b1;
    bus.bin = v;
    @(negedge clk);
    bus.ld  = 1'b0;
    bus.bin = 8'hA5;
  endtask

  // Count negedges since the ld edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
  endtask

  task automatic convert(input string name, input logic [WIDTH-1:0] v, input logic [BW-1:0] exp);
    int lat;
    do_ld(v);
    chk({name, "_busy0"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'd8);
    chk({name, "_bcd"}, 32'(bus.bcd), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    rst     = 1'b1;
    bus.ld  = 1'b0;
    bus.bin = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_bcd",  32'(bus.bcd),  32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // Product 11*13
    convert("c143", 8'h8F, 12'h143);
    @(negedge clk);
    chk("c143_done_1cyc", 32'(bus.done), 32'd0);
    chk("c143_hold", 32'(bus.bcd), 32'h143);

    convert("c000", 8'd0,   12'h000);
    convert("c255", 8'd255, 12'h255);
    convert("c099", 8'd99,  12'h099);
    convert("c100", 8'd100, 12'h100);

    // ld during a conversion is ignored
    do_ld(8'd200);
    for (int i = 1; i < 3; i++) @(negedge clk);
    bus.ld  = 1'b1;
    bus.bin = 8'd7;
    @(negedge clk);
    bus.ld  = 1'b0;
    lat = -1;
    for (int i = 4; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'd8);
    chk("ign_bcd", 32'(bus.bcd), 32'h200);
    count_dones(12, n);
    chk("ign_no_second", 32'(n), 32'd0);

    // Back-to-back: new ld on the done cycle
    do_ld(8'd57);
    wait_done(lat);
    chk("b2b_lat1", 32'(lat), 32'd8);
    chk("b2b_bcd1", 32'(bus.bcd), 32'h057);
    bus.ld  = 1'b1;
    bus.bin = 8'd128;
    @(negedge clk);
    bus.ld  = 1'b0;
    chk("b2b_done_drop", 32'(bus.done), 32'd0);
    chk("b2b_busy",      32'(bus.busy), 32'd1);
    chk("b2b_hold",      32'(bus.bcd),  32'h057);
    wait_done(lat);
    chk("b2b_lat2", 32'(lat), 32'd8);
    chk("b2b_bcd2", 32'(bus.bcd), 32'h128);

    // Reset mid-conversion
    do_ld(8'd250);
    for (int i = 1; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_bcd",  32'(bus.bcd),  32'h0);
    count_dones(12, n);
    chk("mrst_no_done", 32'(n), 32'd0);
    convert("c003", 8'd3, 12'h003);

    // ld and rst on the same edge
    @(negedge clk);
    bus.ld  = 1'b1;
    bus.bin = 8'd77;
    rst     = 1'b1;
    @(negedge clk);
    bus.ld  = 1'b0;
    rst     = 1'b0;
    chk("ldrst_busy", 32'(bus.busy), 32'd0);
    chk("ldrst_bcd",  32'(bus.bcd),  32'h0);
    count_dones(12, n);
    chk("ldrst_no_done", 32'(n), 32'd0);
    chk("ldrst_busy_end", 32'(bus.busy), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift/add-3, "double dabble") that sits directly downstream of the 4x4 shift-add multiplier.
- Takes the multiplier's 8-bit product and produces packed decimal digits for the seven-segment display driver.
- Processes one bit per clock and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, bit width of the binary input (multiplier product width).
- DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ld  input  1  start request; samples bin when the block is idle.
- bin  input  WIDTH  unsigned binary value (multiplier ry).
- bcd  output  4*DIGITS  packed result; the most significant digit is in the top nibble.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has been updated.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state=IDLE, bcd=0, busy=0, done=0, and clears the internal shift and count registers.
  - rst has priority over ld and over any conversion in progress.
  - Reset mid-conversion abandons the conversion; bcd stays 0 and no done pulse is issued.
- State machine has two states: IDLE and SHIFT.
- IDLE:
  - ld=1 at an edge (edge 0): bin is loaded into the internal binary shift register, the scratch BCD register is cleared, count is set to WIDTH, and busy=1 from edge 0.
  - The next state is SHIFT.
  - ld=0 keeps the block in IDLE.
- SHIFT, one bit per edge:
  - Each scratch digit that is >= 5 has 3 added to it, with all digits corrected in parallel.
  - The concatenation {scratch, binreg} is then shifted left by 1.
  - count is decremented.
- Completion on the WIDTH-th SHIFT edge (edge WIDTH, i.e. the WIDTH-th edge after edge 0):
  - The final shifted scratch value is written to bcd.
  - done=1 and busy=0 for exactly the following cycle.
  - The next state is IDLE.
- Latency: WIDTH clocks from the ld edge to the edge that raises done. The default WIDTH=8 gives 8 clocks.
- bcd holds its last completed value until the next completion. It never shows partial results.
- ld while busy=1 is ignored. bin is not re-sampled and the conversion in flight is unaffected.
- ld=1 in the cycle where done=1 is accepted, because the state is already IDLE. This gives back-to-back conversions with no dead cycle. done deasserts at that edge.
- bin only needs to be valid at the ld edge. Changes to bin afterwards have no effect.
- Arithmetic rules:
  - All values are unsigned.
  - Each digit is 4 bits, and after the add-3 correction it never exceeds 9 once shifted.
  - The top digit cannot overflow, given the DIGITS constraint.
- done and busy are never both high.

Test Plan:
- Reset, then ld=1 for one cycle with bin=8'h8F (143 = 11*13 product) -> busy high for 8 cycles, then done pulses once with bcd=12'h143 and busy=0.
- Boundary values converted in turn: bin=0 -> bcd=12'h000; bin=8'd255 -> bcd=12'h255; bin=8'd99 -> bcd=12'h099; bin=8'd100 -> bcd=12'h100. Each done arrives exactly 8 clocks after its ld edge.
- Start a conversion of bin=8'd200, then pulse ld with bin=8'd7 at cycle 3 of the conversion -> the second ld is ignored, bcd=12'h200 at done, and no second done follows.
- Start bin=8'd57, and on the cycle done=1 assert ld with bin=8'd128 -> first result bcd=12'h057, second done exactly 8 clocks later with bcd=12'h128.
- Start bin=8'd250, assert rst at cycle 4 -> busy=0, done=0 and bcd=0 after the rst edge, with no done pulse afterwards. A fresh ld with bin=8'd3 then yields bcd=12'h003.
- Assert ld and rst together on the same edge -> block stays in IDLE, busy=0 and no conversion runs.
